// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: merges load-use, branch flush and dmem wait into per-stage pipeline controls
module pipeline_hazard_ctrl #(
  parameter int ZERO_REG       = 31,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [4:0] ZR = 5'(ZERO_REG);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;
  state_t state, next_state;
  logic [WW-1:0] wait_cnt;
  logic lu, eval, hold, take, stall;
  assign lu = idex_memread & (idex_rd != ZR) & (idex_rd == ifid_rn | idex_rd == ifid_rm);
  // a non-busy cycle in RUN or MEM_WAIT is evaluated with full RUN priority
  assign eval = ~reset & (state != TIMEOUT) & ~dmem_busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      if (dmem_busy && state == RUN) wait_cnt <= WW'(1);
      else if (dmem_busy && state == MEM_WAIT) wait_cnt <= wait_cnt + WW'(1);
      else if (state != TIMEOUT) wait_cnt <= '0;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (take && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    next_state = reset ? RUN :
                 state == TIMEOUT ? TIMEOUT :
                 !dmem_busy ? RUN :
                 (state == MEM_WAIT && wait_cnt == WW'(TIMEOUT_CYCLES - 1)) ? TIMEOUT : MEM_WAIT;
  end
  always_comb begin
    hold        = ~reset & (state == TIMEOUT | dmem_busy);
    take        = eval & branch_taken;
    stall       = eval & ~branch_taken & lu;
    pc_we       = ~reset & ~hold & ~stall;
    ifid_we     = ~reset & ~hold & ~stall;
    idex_bubble = reset | stall;
    ifid_flush  = reset | take;
    idex_flush  = reset | take;
    exmem_flush = reset | take;
    freeze      = hold;
    mem_timeout = ~reset & (state == TIMEOUT);
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl (TIMEOUT_CYCLES=8, CNT_W=2)
module tb_pipeline_hazard_ctrl;
  logic clk = 0, reset;
  logic [4:0] ifid_rn, ifid_rm, idex_rd;
  logic idex_memread, branch_taken, dmem_busy;
  logic pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush, freeze, mem_timeout;
  logic [1:0] stall_cnt, flush_cnt;
  logic [11:0] got, e;
  logic [11:0] exp_q[$];
  int compared = 0, mismatched = 0;
  typedef struct packed {
    logic rst;
    logic [4:0] rn, rm, rd;
    logic mr, br, busy;
    logic [11:0] exp;
  } row_t;
  pipeline_hazard_ctrl #(.ZERO_REG(31), .TIMEOUT_CYCLES(8), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .freeze(freeze),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  // control byte order: pc_we ifid_we idex_bubble ifid_flush idex_flush exmem_flush freeze mem_timeout
  assign got = {pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush, freeze, mem_timeout,
                stall_cnt, flush_cnt};
  localparam logic [7:0] C_RUN = 8'hC0, C_LU = 8'h20, C_BR = 8'hDC, C_FRZ = 8'h02,
                         C_TO = 8'h03, C_RST = 8'h3C;
  function automatic row_t mk(input logic rst, input logic [4:0] rn, rm, rd, input logic mr, br,
                              busy, input logic [7:0] ctrl, input int st, input int fl);
    mk = '{rst, rn, rm, rd, mr, br, busy, {ctrl, 2'(st), 2'(fl)}};
  endfunction
  task automatic drive(input row_t r);
    reset = r.rst; ifid_rn = r.rn; ifid_rm = r.rm; idex_rd = r.rd;
    idex_memread = r.mr; branch_taken = r.br; dmem_busy = r.busy;
    exp_q.push_back(r.exp);
  endtask
  task automatic test_reset;
    row_t r[$];
    r.push_back(mk(1, 3, 3, 3, 1, 1, 1, C_RST, 0, 0));
    r.push_back(mk(1, 0, 0, 0, 0, 0, 0, C_RST, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      e = exp_q.pop_front(); compared++;
      if (got !== e) begin mismatched++; $display("FAIL reset row %0d: got %h expected %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_use;
    row_t r[$];
    r.push_back(mk(0, 1, 2, 3, 1, 0, 0, C_RUN, 0, 0));
    r.push_back(mk(0, 3, 2, 3, 1, 0, 0, C_LU, 0, 0));
    r.push_back(mk(0, 1, 2, 3, 1, 0, 0, C_RUN, 1, 0));
    r.push_back(mk(0, 31, 31, 31, 1, 0, 0, C_RUN, 1, 0));
    r.push_back(mk(0, 0, 0, 0, 1, 0, 0, C_LU, 1, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 2, 0));
    r.push_back(mk(0, 1, 5, 5, 1, 0, 0, C_LU, 2, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 3, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      e = exp_q.pop_front(); compared++;
      if (got !== e) begin mismatched++; $display("FAIL load_use row %0d: got %h expected %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch_priority;
    row_t r[$];
    r.push_back(mk(1, 0, 0, 0, 0, 0, 0, C_RST, 3, 0));
    r.push_back(mk(0, 4, 4, 4, 1, 1, 0, C_BR, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      e = exp_q.pop_front(); compared++;
      if (got !== e) begin mismatched++; $display("FAIL branch_priority row %0d: got %h expected %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mem_wait;
    row_t r[$];
    for (int k = 0; k < 5; k++) r.push_back(mk(0, 4, 0, 4, 1, 1, 1, C_FRZ, 0, 1));
    r.push_back(mk(0, 4, 0, 4, 1, 1, 0, C_BR, 0, 1));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, C_FRZ, 0, 2));
    r.push_back(mk(0, 6, 0, 6, 1, 0, 0, C_LU, 0, 2));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 2));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      e = exp_q.pop_front(); compared++;
      if (got !== e) begin mismatched++; $display("FAIL mem_wait row %0d: got %h expected %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_watchdog;
    row_t r[$];
    r.push_back(mk(1, 0, 0, 0, 0, 0, 0, C_RST, 1, 2));
    for (int k = 1; k <= 8; k++) r.push_back(mk(0, 0, 0, 0, 0, 0, 1, C_FRZ, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, C_TO, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, C_TO, 0, 0));
    r.push_back(mk(0, 4, 0, 4, 1, 1, 0, C_TO, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_TO, 0, 0));
    r.push_back(mk(1, 0, 0, 0, 0, 0, 0, C_RST, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      e = exp_q.pop_front(); compared++;
      if (got !== e) begin mismatched++; $display("FAIL watchdog row %0d: got %h expected %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_saturation_reset;
    row_t r[$];
    for (int k = 0; k < 5; k++) r.push_back(mk(0, 7, 0, 7, 1, 0, 0, C_LU, k > 3 ? 3 : k, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 3, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, C_FRZ, 3, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, C_FRZ, 3, 0));
    r.push_back(mk(1, 0, 0, 0, 0, 1, 1, C_RST, 3, 0));
    r.push_back(mk(0, 7, 0, 7, 1, 0, 0, C_LU, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, C_RUN, 1, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      e = exp_q.pop_front(); compared++;
      if (got !== e) begin mismatched++; $display("FAIL saturation_reset row %0d: got %h expected %h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    reset = 1; ifid_rn = 0; ifid_rm = 0; idex_rd = 0;
    idex_memread = 0; branch_taken = 0; dmem_busy = 0;
    @(posedge clk); #1;
    test_reset;
    test_load_use;
    test_branch_priority;
    test_mem_wait;
    test_watchdog;
    test_saturation_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
